// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and elaboration helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Index width for NUM_REQ producers, never narrower than one bit.
   function automatic int id_width(input int n);
      return (clog2(n) > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping at NUM_REQ.
// Zero latency; no flow control of its own.
module rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]           req,
   input  logic [id_width(NUM_REQ)-1:0] ptr,
   output logic                         vld,
   output logic [id_width(NUM_REQ)-1:0] idx
);
   localparam int ID_W = id_width(NUM_REQ);
   localparam int CW   = ID_W + 1;

   // One extra bit so ptr+i can exceed NUM_REQ before the explicit wrap.
   logic [CW-1:0] cand;

   always_comb begin
      vld  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr} + CW'(i);
         if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
         if (!vld && req[cand[ID_W-1:0]]) begin
            vld = 1'b1;
            idx = cand[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of one FIFO write port among NUM_REQ producers, up to MAX_BURST beats per grant.
// One cycle grant latency from idle, none between grants; fifo_wr_ready low holds the grant indefinitely.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_vld,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic                           fifo_wr_en,
   output logic [DATA_WIDTH-1:0]          fifo_wr_data,
   input  logic                           fifo_wr_ready,
   output logic                           grant_vld,
   output logic [id_width(NUM_REQ)-1:0]   grant_id
);
   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = clog2(MAX_BURST + 1);

   state_t            state, state_nxt;
   logic [ID_W-1:0]   grant_nxt, rr_ptr, ptr_nxt, g_inc, pick_ptr, pick_idx;
   logic [CNT_W-1:0]  beat_cnt, cnt_nxt;
   logic              sel_vld, beat, rel, pick_vld;
   logic [DATA_WIDTH-1:0] sel_data;

   always_comb begin
      sel_vld  = 1'b0;
      sel_data = '0;
      req_ack  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_vld  = req_vld[i];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            req_ack[i] = beat;
         end
      end
   end

   assign grant_vld    = (state == ST_BUSY);
   assign fifo_wr_en   = grant_vld & sel_vld;
   assign fifo_wr_data = grant_vld ? sel_data : '0;
   assign beat         = fifo_wr_en & fifo_wr_ready;
   assign rel          = grant_vld & (~sel_vld | (beat & (beat_cnt == CNT_W'(MAX_BURST - 1))));
   assign g_inc        = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   // Re-arbitration on release scans from g+1, so the releasing producer comes last.
   assign pick_ptr = grant_vld ? g_inc : rr_ptr;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req (req_vld),
      .ptr (pick_ptr),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      cnt_nxt   = beat_cnt;
      ptr_nxt   = rr_ptr;
      if (state == ST_IDLE) begin
         if (pick_vld) begin
            state_nxt = ST_BUSY;
            grant_nxt = pick_idx;
            cnt_nxt   = '0;
         end
      end else if (rel) begin
         ptr_nxt   = g_inc;
         cnt_nxt   = '0;
         state_nxt = pick_vld ? ST_BUSY : ST_IDLE;
         if (pick_vld) grant_nxt = pick_idx;
      end else if (beat) begin
         cnt_nxt = beat_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         grant_id <= '0;
         beat_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         beat_cnt <= cnt_nxt;
         rr_ptr   <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_wr_arbiter;
   localparam int NR = 4;
   localparam int DW = 4;
   localparam int MB = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR-1:0]   req_vld;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ack;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic            fifo_wr_ready;
   logic            grant_vld;
   logic [1:0]      grant_id;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_vld       (req_vld),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wr_data  (fifo_wr_data),
      .fifo_wr_ready (fifo_wr_ready),
      .grant_vld     (grant_vld),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   int total, bad;
   // Producer beat queues, enable mask and FIFO-side ready mode (0 drained, 1 depth-3 undrained, 2 stalled, 3 random)
   logic [DW-1:0] pq [NR][$];
   logic [NR-1:0] en, vld;
   logic [NR*DW-1:0] dat;
   logic          rdy;
   int            rdy_mode, fifo_cnt, ack_count;
   logic [DW-1:0] got [$];
   // Reference model of the grant
   bit            m_busy;
   logic [1:0]    m_g, m_ptr;
   int            m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NR-1:0] v, input int start);
      for (int k = 0; k < NR; k++)
         if (v[2'((start + k) % NR)]) return (start + k) % NR;
      return -1;
   endfunction

   task automatic drive();
      logic [NR-1:0] exp_ack;
      logic [DW-1:0] exp_dat;
      logic          exp_en;
      for (int i = 0; i < NR; i++) begin
         vld[i] = en[i] && (pq[i].size() > 0);
         dat[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 4'h0;
      end
      case (rdy_mode)
         0:       rdy = 1'b1;
         1:       rdy = (fifo_cnt < 3);
         2:       rdy = 1'b0;
         default: rdy = 1'($urandom_range(0, 1));
      endcase
      req_vld = vld;
      req_data = dat;
      fifo_wr_ready = rdy;
      #2;
      exp_en = 1'b0;
      exp_dat = '0;
      exp_ack = '0;
      if (m_busy) begin
         exp_en = vld[m_g];
         exp_dat = dat[int'(m_g)*DW +: DW];
         if (vld[m_g] && rdy) exp_ack[m_g] = 1'b1;
      end
      chk("grant_vld", 32'(grant_vld), 32'(m_busy));
      if (m_busy) chk("grant_id", 32'(grant_id), 32'(m_g));
      chk("wr_en", 32'(fifo_wr_en), 32'(exp_en));
      chk("wr_data", 32'(fifo_wr_data), 32'(exp_dat));
      chk("req_ack", 32'(req_ack), 32'(exp_ack));
      if (fifo_wr_en && fifo_wr_ready) got.push_back(fifo_wr_data);
      if (req_ack != '0) ack_count++;
   endtask

   task automatic advance();
      int p;
      bit beat;
      @(posedge clk);
      beat = m_busy && vld[m_g] && rdy;
      if (beat) begin
         void'(pq[m_g].pop_front());
         fifo_cnt++;
      end
      if (m_busy && (!vld[m_g] || (beat && m_cnt + 1 == MB))) begin
         m_ptr = 2'((int'(m_g) + 1) % NR);
         p = pick(vld, int'(m_ptr));
         m_busy = (p >= 0);
         m_cnt = 0;
         if (p >= 0) m_g = 2'(p);
      end else if (m_busy) begin
         if (beat) m_cnt++;
      end else begin
         p = pick(vld, int'(m_ptr));
         if (p >= 0) begin
            m_busy = 1'b1;
            m_g = 2'(p);
            m_cnt = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      drive();
      advance();
   endtask

   task automatic do_reset(input bit check);
      reset = 1'b0;
      #1;
      if (check) begin
         chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
         chk("rst_ack", 32'(req_ack), 32'd0);
         chk("rst_grant_vld", 32'(grant_vld), 32'd0);
         chk("rst_grant_id", 32'(grant_id), 32'd0);
         chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
      end
      for (int i = 0; i < NR; i++) pq[i].delete();
      got.delete();
      en = '0;
      req_vld = '0;
      req_data = '0;
      fifo_cnt = 0;
      ack_count = 0;
      rdy_mode = 0;
      m_busy = 1'b0;
      m_g = '0;
      m_ptr = '0;
      m_cnt = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int exp3 [9];
      total = 0;
      bad = 0;
      reset = 1'b0;
      req_vld = '0;
      req_data = '0;
      fifo_wr_ready = 1'b0;
      exp3 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      #3;
      do_reset(1);

      // Async reset mid-burst with all producers requesting
      for (int i = 0; i < NR; i++) for (int k = 0; k < 4; k++) pq[i].push_back(4'(i + k));
      en = 4'hF;
      for (int s = 0; s < 3; s++) step();
      #3;
      do_reset(1);

      // Lone producer: burst of two, immediate re-grant, third beat
      pq[1] = '{4'd7, 4'd6, 4'd5};
      en = 4'b0010;
      step();
      drive();
      chk("t2_gid", 32'(grant_id), 32'd1);
      advance();
      step();
      step();
      chk("t2_cnt", 32'(got.size()), 32'd3);
      chk("t2_d0", 32'(got[0]), 32'd7);
      chk("t2_d1", 32'(got[1]), 32'd6);
      chk("t2_d2", 32'(got[2]), 32'd5);
      step();
      do_reset(0);

      // All requesting: 0,0,1,1,2,2,3,3,0 without bubbles
      for (int i = 0; i < NR; i++) for (int k = 0; k < 6; k++) pq[i].push_back(4'(4 * i + k));
      en = 4'hF;
      step();
      for (int k = 0; k < 9; k++) begin
         drive();
         chk("t3_vld", 32'(grant_vld), 32'd1);
         chk("t3_gid", 32'(grant_id), 32'(exp3[k]));
         advance();
      end
      do_reset(0);

      // FIFO stall mid-burst holds grant and beat count
      pq[2] = '{4'd1, 4'd2, 4'd3};
      en = 4'b0100;
      step();
      step();
      rdy_mode = 2;
      for (int s = 0; s < 3; s++) begin
         drive();
         chk("t4_en", 32'(fifo_wr_en), 32'd1);
         chk("t4_ack", 32'(req_ack), 32'd0);
         chk("t4_cnt", 32'(dut.beat_cnt), 32'd1);
         advance();
      end
      rdy_mode = 0;
      drive();
      chk("t4_data", 32'(fifo_wr_data), 32'd2);
      chk("t4_ack2", 32'(req_ack), 32'b0100);
      advance();
      step();
      step();
      do_reset(0);

      // Producer 0 drops after one beat; producer 3 takes over
      pq[0] = '{4'd8, 4'd9};
      pq[3] = '{4'd10};
      en = 4'b1001;
      step();
      step();
      en = 4'b1000;
      step();
      drive();
      chk("t5_gid", 32'(grant_id), 32'd3);
      chk("t5_ptr", 32'(dut.rr_ptr), 32'd1);
      advance();
      step();
      do_reset(0);

      // Undrained depth-3 FIFO: exactly three beats, in grant order
      for (int i = 0; i < NR; i++) pq[i] = '{4'(2 * i + 1), 4'(2 * i + 2)};
      en = 4'hF;
      rdy_mode = 1;
      for (int s = 0; s < 10; s++) step();
      chk("t6_acks", 32'(ack_count), 32'd3);
      chk("t6_size", 32'(got.size()), 32'd3);
      chk("t6_d0", 32'(got[0]), 32'd1);
      chk("t6_d1", 32'(got[1]), 32'd2);
      chk("t6_d2", 32'(got[2]), 32'd3);
      do_reset(0);

      // Random traffic
      rdy_mode = 3;
      for (int s = 0; s < 400; s++) begin
         for (int i = 0; i < NR; i++)
            if (pq[i].size() < 3) pq[i].push_back(4'($urandom));
         en = 4'($urandom) | 4'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
